seq_arith_unit: RTL and testbench

- Parametrised, handshaked, multi-cycle arithmetic unit; next generation of the team's registered adder, aligner and max blocks.
- Performs add-with-carry, subtract-with-borrow, max, and iterative normalise (left-align to MSB with shift count).
- Sits between a command source (start/op) and a consumer that samples registered results on a one-cycle done pulse.

---
 rtl/seq_arith_unit.sv | 161 ++++++++++++++++
 tb/tb_seq_arith_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_unit.sv
// Multi-cycle arithmetic unit: ADD with carry, SUB with borrow, unsigned MAX, NORM (left-align to MSB).
// Latency: done one cycle after the accept edge; nonzero NORM takes one extra cycle per leading zero.
// Backpressure: no queuing. start is ignored while busy and in the done cycle; the caller must retry.
//
// Ports: clk, reset (async active-low); command start/op/data_a/data_b/c_in;
//        status busy, done (1-cycle pulse); registered results result/c_out/zero/shift_cnt.
// Optional build macro SEQ_ARITH_SAT_EN: ADD saturates to all-ones on carry, SUB saturates to 0 on borrow.
module seq_arith_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero,
  output logic [CNT_W-1:0] shift_cnt
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MAX  = 2'b10;
  localparam logic [1:0] OP_NORM = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    NORM = 2'b10
  } state_t;

  state_t           state, state_n;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;      // a_q doubles as the NORM shift register
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept, fin, shift_en;
  logic [WIDTH-1:0] res_n;
  logic             cout_n;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH:0]   sum, diff;

  // done is checked so a start coinciding with the completion pulse is dropped.
  assign accept = (state == IDLE) && start && !done;
  assign busy   = (state != IDLE);

  // One extra bit holds the carry (ADD) or the borrow (SUB, wraps to 1 when negative).
  assign sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, c_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    fin      = 1'b0;
    shift_en = 1'b0;
    res_n    = result;
    cout_n   = 1'b0;
    cnt_n    = '0;
    case (state)
      IDLE: begin
        if (accept) state_n = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_ADD: begin
            fin    = 1'b1;
            cout_n = sum[WIDTH];
`ifdef SEQ_ARITH_SAT_EN
            res_n  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
            res_n  = sum[WIDTH-1:0];
`endif
          end
          OP_SUB: begin
            fin    = 1'b1;
            cout_n = diff[WIDTH];
`ifdef SEQ_ARITH_SAT_EN
            res_n  = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
            res_n  = diff[WIDTH-1:0];
`endif
          end
          OP_MAX: begin
            fin   = 1'b1;
            res_n = (a_q >= b_q) ? a_q : b_q;
          end
          OP_NORM: begin
            if (a_q == '0) begin
              fin   = 1'b1;
              res_n = '0;
            end else if (a_q[WIDTH-1]) begin
              fin   = 1'b1;
              res_n = a_q;
            end else begin
              // First shift happens on the way into NORM, so k zeros finish k cycles later.
              state_n  = NORM;
              shift_en = 1'b1;
            end
          end
          default: fin = 1'b1;
        endcase
      end
      NORM: begin
        if (a_q[WIDTH-1]) begin
          fin   = 1'b1;
          res_n = a_q;
          cnt_n = cnt_q;
        end else begin
          shift_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (fin) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      done      <= 1'b0;
      result    <= '0;
      c_out     <= 1'b0;
      zero      <= 1'b0;
      shift_cnt <= '0;
    end else begin
      done <= fin;
      if (accept) begin
        op_q  <= op;
        a_q   <= data_a;
        b_q   <= data_b;
        c_q   <= c_in;
        cnt_q <= '0;
      end else if (shift_en) begin
        a_q   <= a_q << 1;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (fin) begin
        result    <= res_n;
        c_out     <= cout_n;
        zero      <= (res_n == '0);
        shift_cnt <= cnt_n;
      end
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
module tb_seq_arith_unit;

`ifdef SEQ_ARITH_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       c_in = 1'b0;
  logic       busy, done, c_out, zero;
  logic [7:0] result;
  logic [3:0] shift_cnt;

  seq_arith_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .data_a(data_a), .data_b(data_b), .c_in(c_in),
    .busy(busy), .done(done), .result(result), .c_out(c_out),
    .zero(zero), .shift_cnt(shift_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Driver-owned: model prediction for the op in flight.
  int issued = 0;
  int due = 0;
  int t_acc = 0;
  int nxt_res, nxt_co, nxt_z, nxt_sc;
  bit lit_vld = 0;
  int lit_res, lit_co, lit_z, lit_sc, lit_lat;

  // Compare-owned state.
  int completed = 0;
  int exp_res = 0, exp_co = 0, exp_z = 0, exp_sc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules.
  task automatic model(input int o, input int a, input int b, input int ci,
                       output int r, output int co, output int z, output int sc, output int lat);
    int v;
    r = 0; co = 0; sc = 0; lat = 1;
    case (o)
      0: begin
        v = a + b + ci;
        co = (v > 255) ? 1 : 0;
        r = v % 256;
        if (SAT && co == 1) r = 255;
      end
      1: begin
        v = a - b - ci;
        co = (v < 0) ? 1 : 0;
        r = (v + 256) % 256;
        if (SAT && co == 1) r = 0;
      end
      2: r = (a >= b) ? a : b;
      default: begin
        v = a;
        if (v != 0) while (v < 128) begin v = v * 2; sc++; end
        r = v;
        lat = 1 + sc;
      end
    endcase
    z = (r == 0) ? 1 : 0;
  endtask

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    bit e_done, e_busy;
    if (!reset) begin
      completed = issued;
      exp_res = 0; exp_co = 0; exp_z = 0; exp_sc = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_c_out", c_out, 0);
      chk("rst_zero", zero, 0);
      chk("rst_shift_cnt", shift_cnt, 0);
    end else begin
      e_done = (issued != completed) && (cyc == due);
      e_busy = (issued != completed) && (cyc < due);
      if (e_done) begin
        exp_res = nxt_res; exp_co = nxt_co; exp_z = nxt_z; exp_sc = nxt_sc;
        completed = issued;
      end
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      chk("result", result, exp_res);
      chk("c_out", c_out, exp_co);
      chk("zero", zero, exp_z);
      chk("shift_cnt", shift_cnt, exp_sc);
      if (e_done && lit_vld) begin
        chk("lit_latency", cyc - t_acc, lit_lat);
        chk("lit_result", result, lit_res);
        chk("lit_c_out", c_out, lit_co);
        chk("lit_zero", zero, lit_z);
        chk("lit_shift_cnt", shift_cnt, lit_sc);
      end
    end
  end

  // Drive a command that the DUT must accept; lv=0 skips the literal pin.
  task automatic issue(input int o, input int a, input int b, input int ci, input bit lv,
                       input int lr, input int lc, input int lz, input int ls, input int ll);
    int r, co, z, sc, lat;
    @(negedge clk);
    start = 1'b1; op = 2'(o); data_a = 8'(a); data_b = 8'(b); c_in = 1'(ci);
    model(o, a, b, ci, r, co, z, sc, lat);
    nxt_res = r; nxt_co = co; nxt_z = z; nxt_sc = sc;
    lit_vld = lv; lit_res = lr; lit_co = lc; lit_z = lz; lit_sc = ls; lit_lat = ll;
    @(posedge clk);
    #1;
    start = 1'b0;
    t_acc = cyc;
    due = cyc + lat;
    issued++;
  endtask

  // Pulse start without expecting acceptance; starts on the current or next negedge.
  task automatic poke(input bit now, input int o, input int a, input int b, input int ci);
    if (!now) @(negedge clk);
    start = 1'b1; op = 2'(o); data_a = 8'(a); data_b = 8'(b); c_in = 1'(ci);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_op;
    while (cyc <= due) @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // ADD 0xF0+0x0F+1 carries out.
    issue(0, 8'hF0, 8'h0F, 1, 1, SAT ? 8'hFF : 8'h00, 1, SAT ? 0 : 1, 0, 1);
    finish_op();
    // SUB 0x05-0x07 borrows.
    issue(1, 8'h05, 8'h07, 0, 1, SAT ? 8'h00 : 8'hFE, 1, SAT ? 1 : 0, 0, 1);
    finish_op();
    // MAX equal operands, then B larger (c_in set, must be ignored).
    issue(2, 8'h3C, 8'h3C, 0, 1, 8'h3C, 0, 0, 0, 1);
    finish_op();
    issue(2, 8'h10, 8'hA0, 1, 1, 8'hA0, 0, 0, 0, 1);
    finish_op();
    // NORM: five leading zeros, zero operand, already aligned.
    issue(3, 8'h05, 8'h77, 1, 1, 8'hA0, 0, 0, 5, 6);
    finish_op();
    issue(3, 8'h00, 8'h12, 0, 1, 8'h00, 0, 1, 0, 1);
    finish_op();
    issue(3, 8'h80, 8'h00, 0, 1, 8'h80, 0, 0, 0, 1);
    finish_op();
    // NORM 0x01 with ADD starts thrown at it while busy.
    issue(3, 8'h01, 8'h00, 0, 1, 8'h80, 0, 0, 7, 8);
    poke(0, 0, 8'h11, 8'h22, 0);
    poke(0, 0, 8'h11, 8'h22, 0);
    finish_op();
    // Start during the done pulse is dropped; the following cycle is accepted.
    issue(0, 8'h01, 8'h02, 0, 1, 8'h03, 0, 0, 0, 1);
    while (cyc < due) @(negedge clk);
    poke(1, 1, 8'h40, 8'h01, 0);
    issue(0, 8'hFF, 8'h00, 1, 1, SAT ? 8'hFF : 8'h00, 1, SAT ? 0 : 1, 0, 1);
    finish_op();
    // Reset in the middle of NORM aborts it.
    issue(3, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    // First command after reset.
    issue(1, 8'h10, 8'h01, 1, 1, 8'h0E, 0, 0, 0, 1);
    finish_op();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
